// File: rtl/tact_pkg.sv
// Shared definitions for the tact switch conditioning path: pin polarity and
// the debounce FSM state encoding, so every consumer agrees on both.
package tact_pkg;

    localparam logic TACT_ON  = 1'b0;
    localparam logic TACT_OFF = 1'b1;

    typedef enum logic [1:0] {
        S_UP      = 2'd0,
        S_DN_WAIT = 2'd1,
        S_DOWN    = 2'd2,
        S_UP_WAIT = 2'd3
    } tact_state_e;

endpackage

// File: rtl/tact_debounce_if.sv
// Switch-side bundle: raw pin in, debounced level and event pulses out.
interface tact_debounce_if;

    logic Tact_raw;
    logic Tact_db;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    // master: board pin driver and event consumer; slave: the debouncer
    modport master (
        output Tact_raw,
        input  Tact_db, pressed, press_pulse, release_pulse, long_press
    );

    modport slave (
        input  Tact_raw,
        output Tact_db, pressed, press_pulse, release_pulse, long_press
    );

endinterface

// File: rtl/tact_sync.sv
// Two-flop synchroniser for a slow asynchronous board input; the reset value
// is a parameter so an idle pin never looks like an event after reset.
module tact_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/tact_debounce.sv
// Debounces the tact switch into a clean level plus press, release and
// long-press pulses; all outputs registered.
module tact_debounce #(
    parameter logic TACT_ON     = 1'b0,
    parameter logic TACT_OFF    = 1'b1,
    parameter int   W_DB        = 18,
    parameter int   DB_CYCLES   = 240000,
    parameter int   W_LONG      = 25,
    parameter int   LONG_CYCLES = 24000000
) (
    input  logic           CLK_24MHz,
    input  logic           RST,
    tact_debounce_if.slave bus
);

    import tact_pkg::*;

    localparam logic [W_DB-1:0]   DB_LAST   = W_DB'(DB_CYCLES - 1);
    localparam logic [W_LONG-1:0] LONG_LAST = W_LONG'(LONG_CYCLES - 1);
    localparam logic [W_DB-1:0]   DB_ONE    = W_DB'(1);
    localparam logic [W_LONG-1:0] LONG_ONE  = W_LONG'(1);

    logic              s2;
    tact_state_e       state_q, state_d;
    logic [W_DB-1:0]   db_cnt_q, db_cnt_d;
    logic [W_LONG-1:0] long_cnt_q, long_cnt_d;
    logic              long_fired_q, long_fired_d;
    logic              tact_db_q, tact_db_d;
    logic              pressed_q, pressed_d;
    logic              press_pulse_q, press_pulse_d;
    logic              release_pulse_q, release_pulse_d;
    logic              long_press_q, long_press_d;
    logic              db_done;
    logic              long_hit;

    tact_sync #(
        .RST_VAL (TACT_OFF)
    ) u_sync (
        .clk_i (CLK_24MHz),
        .rst_i (RST),
        .d_i   (bus.Tact_raw),
        .q_o   (s2)
    );

    // >= rather than == keeps DB_CYCLES=1 accepting on the first WAIT cycle
    assign db_done  = (db_cnt_q >= DB_LAST);
    assign long_hit = !long_fired_q && (long_cnt_q == LONG_LAST);

    always_ff @(posedge CLK_24MHz) begin
        if (RST) begin
            state_q         <= S_UP;
            db_cnt_q        <= '0;
            long_cnt_q      <= '0;
            long_fired_q    <= 1'b0;
            tact_db_q       <= TACT_OFF;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_press_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            db_cnt_q        <= db_cnt_d;
            long_cnt_q      <= long_cnt_d;
            long_fired_q    <= long_fired_d;
            tact_db_q       <= tact_db_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_press_q    <= long_press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_UP:      if (s2 == TACT_ON) state_d = S_DN_WAIT;
            S_DN_WAIT: begin
                if (s2 == TACT_OFF) state_d = S_UP;
                else if (db_done)   state_d = S_DOWN;
            end
            S_DOWN:    if (s2 == TACT_OFF) state_d = S_UP_WAIT;
            S_UP_WAIT: begin
                if (s2 == TACT_ON) state_d = S_DOWN;
                else if (db_done)  state_d = S_UP;
            end
            default:   state_d = S_UP;
        endcase
    end

    always_comb begin
        db_cnt_d        = db_cnt_q;
        long_cnt_d      = long_cnt_q;
        long_fired_d    = long_fired_q;
        tact_db_d       = tact_db_q;
        pressed_d       = pressed_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_press_d    = 1'b0;
        case (state_q)
            S_UP: begin
                db_cnt_d = (s2 == TACT_ON) ? DB_ONE : '0;
            end
            S_DN_WAIT: begin
                if (s2 == TACT_OFF) begin
                    db_cnt_d = '0;
                end else if (db_done) begin
                    db_cnt_d      = '0;
                    tact_db_d     = TACT_ON;
                    pressed_d     = 1'b1;
                    press_pulse_d = 1'b1;
                    long_cnt_d    = '0;
                    long_fired_d  = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            S_DOWN: begin
                db_cnt_d = (s2 == TACT_OFF) ? DB_ONE : '0;
                if (long_hit) begin
                    long_press_d = 1'b1;
                    long_fired_d = 1'b1;
                end else if (!long_fired_q) begin
                    long_cnt_d = long_cnt_q + LONG_ONE;
                end
            end
            S_UP_WAIT: begin
                // long_cnt holds here so a rejected release glitch only pauses the hold timer
                if (s2 == TACT_ON) begin
                    db_cnt_d = '0;
                end else if (db_done) begin
                    db_cnt_d        = '0;
                    tact_db_d       = TACT_OFF;
                    pressed_d       = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            default: db_cnt_d = '0;
        endcase
    end

    assign bus.Tact_db       = tact_db_q;
    assign bus.pressed       = pressed_q;
    assign bus.press_pulse   = press_pulse_q;
    assign bus.release_pulse = release_pulse_q;
    assign bus.long_press    = long_press_q;

endmodule

// File: tb/tb_tact_debounce.sv
// Directed bench for tact_debounce with short debounce and long-press windows.
module tb_tact_debounce;

    import tact_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    int   edge_idx;
    int   press_n, press_at;
    int   rel_n, rel_at;
    int   long_n, long_at;
    int   excl_bad;

    tact_debounce_if bus ();

    tact_debounce #(
        .TACT_ON     (1'b0),
        .TACT_OFF    (1'b1),
        .W_DB        (3),
        .DB_CYCLES   (4),
        .W_LONG      (5),
        .LONG_CYCLES (16)
    ) dut (
        .CLK_24MHz (clk),
        .RST       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        edge_idx = 0;
        press_n = 0; press_at = -1;
        rel_n   = 0; rel_at   = -1;
        long_n  = 0; long_at  = -1;
        excl_bad = 0;
    endtask

    // Advance n rising edges, logging where each pulse appears (sampled 1 ns after the edge)
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_idx++;
            if (bus.press_pulse)   begin press_n++; press_at = edge_idx; end
            if (bus.release_pulse) begin rel_n++;   rel_at   = edge_idx; end
            if (bus.long_press)    begin long_n++;  long_at  = edge_idx; end
            if ((bus.press_pulse && bus.release_pulse) || (bus.press_pulse && bus.long_press))
                excl_bad++;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.Tact_raw = 1'b1;
        clear_log();
        watch(2);
        check("rst_tact_db", bus.Tact_db, 1);
        check("rst_pressed", bus.pressed, 0);
        check("rst_pulses", {bus.press_pulse, bus.release_pulse, bus.long_press}, 0);
        rst = 1'b0;

        // idle released
        clear_log();
        watch(20);
        check("idle_pulses", press_n + rel_n + long_n, 0);
        check("idle_tact_db", bus.Tact_db, 1);
        check("idle_pressed", bus.pressed, 0);

        // clean press: accepted on edge 6, long press 16 edges later, no repeat
        clear_log();
        bus.Tact_raw = 1'b0;
        watch(5);
        check("press_early", press_n, 0);
        check("press_early_db", bus.Tact_db, 1);
        watch(1);
        check("press_at", press_at, 6);
        check("press_db", bus.Tact_db, 0);
        check("press_pressed", bus.pressed, 1);
        watch(1);
        check("press_one_cycle", bus.press_pulse, 0);
        watch(30);
        check("press_count", press_n, 1);
        check("long_count", long_n, 1);
        check("long_at", long_at - press_at, 16);

        // clean release
        clear_log();
        bus.Tact_raw = 1'b1;
        watch(6);
        check("rel_at", rel_at, 6);
        check("rel_count", rel_n, 1);
        check("rel_db", bus.Tact_db, 1);
        check("rel_pressed", bus.pressed, 0);
        watch(4);

        // bounce shorter than the debounce window
        clear_log();
        bus.Tact_raw = 1'b0; watch(3);
        bus.Tact_raw = 1'b1; watch(1);
        bus.Tact_raw = 1'b0; watch(3);
        bus.Tact_raw = 1'b1; watch(10);
        check("bounce_press", press_n, 0);
        check("bounce_db", bus.Tact_db, 1);
        check("bounce_state", int'(dut.state_q), int'(S_UP));

        // release glitch during hold pauses the long-press timer by two cycles
        clear_log();
        bus.Tact_raw = 1'b0;
        watch(6);
        check("gl_press_at", press_at, 6);
        watch(5);
        bus.Tact_raw = 1'b1; watch(2);
        bus.Tact_raw = 1'b0; watch(20);
        check("gl_release", rel_n, 0);
        check("gl_db", bus.Tact_db, 0);
        check("gl_long_at", long_at - press_at, 18);
        check("gl_long_count", long_n, 1);
        clear_log();
        bus.Tact_raw = 1'b1;
        watch(10);
        check("gl_rel_at", rel_at, 6);

        // reset mid S_DN_WAIT with switch held
        clear_log();
        bus.Tact_raw = 1'b0;
        watch(4);
        check("r1_state", int'(dut.state_q), int'(S_DN_WAIT));
        rst = 1'b1;
        watch(1);
        rst = 1'b0;
        check("r1_db", bus.Tact_db, 1);
        check("r1_state_up", int'(dut.state_q), int'(S_UP));
        clear_log();
        watch(6);
        check("r1_press_at", press_at, 6);
        check("r1_pressed", bus.pressed, 1);

        // reset mid S_DOWN with switch held
        watch(3);
        rst = 1'b1;
        watch(1);
        rst = 1'b0;
        check("r2_db", bus.Tact_db, 1);
        check("r2_pressed", bus.pressed, 0);
        check("r2_pulses", {bus.press_pulse, bus.release_pulse, bus.long_press}, 0);
        clear_log();
        watch(6);
        check("r2_press_at", press_at, 6);
        watch(16);
        check("r2_long_at", long_at, 22);
        check("r2_no_release", rel_n, 0);
        bus.Tact_raw = 1'b1;
        watch(8);
        check("r2_rel_count", rel_n, 1);
        check("excl", excl_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tact_debounce.md
Name: tact_debounce

Overview:
- Conditions the raw BeMicro CV tact switch (Tact1, active-low, mechanically bouncy, asynchronous to CLK_24MHz).
- Synchronises it, debounces it, and produces:
  - a clean level with the same polarity as the switch, wired straight into the LED blinker's Tact1 input;
  - one-cycle press, release and long-press event pulses for other consumers.
- Sits between the board pin and the blinker.

Parameters:
- TACT_ON, 1'b0: pin level meaning "pressed".
- TACT_OFF, 1'b1: pin level meaning "released".
- W_DB, 18: debounce counter width; must hold DB_CYCLES-1.
- DB_CYCLES, 240000: cycles the synchronised input must differ from the stable level before it is accepted (10 ms at 24 MHz); legal range is ≥1.
- W_LONG, 25: long-press counter width; must hold LONG_CYCLES-1.
- LONG_CYCLES, 24000000: cycles the debounced pressed level must persist before long_press fires (1 s); legal range is ≥1.

Ports:
- CLK_24MHz  in   1  system clock; all logic on its rising edge.
- RST        in   1  synchronous, active-high reset.
- Tact_raw   in   1  raw switch pin; asynchronous; TACT_ON = pressed.
- Tact_db    out  1  debounced level, same polarity as Tact_raw.
- pressed    out  1  debounced level, active-high (1 = held).
- press_pulse    out 1  one-cycle pulse on an accepted press.
- release_pulse  out 1  one-cycle pulse on an accepted release.
- long_press     out 1  one-cycle pulse once per hold, after LONG_CYCLES.

Behaviour:
- Reset (RST=1 at an edge):
  - synchroniser flops, Tact_db and the state register go to TACT_OFF / S_UP;
  - pressed=0, all pulses 0, both counters 0, long_fired=0.
  - RST has priority over every other event, including mid-debounce or mid-hold. After reset the block behaves as if the switch had been released for ever.
- Synchroniser: two flops, s1<=Tact_raw, s2<=s1. Only s2 is used downstream.
- FSM states:
  - S_UP: stable released; db_cnt=0. If s2==TACT_ON → S_DN_WAIT with db_cnt=1.
  - S_DN_WAIT: if s2==TACT_OFF → S_UP, db_cnt=0 (glitch rejected, no pulse). Else if db_cnt==DB_CYCLES-1 → S_DOWN, Tact_db<=TACT_ON, pressed<=1, press_pulse<=1, long_cnt=0, long_fired=0. Else db_cnt+1.
  - S_DOWN: long_cnt counts up each cycle while long_fired==0. If s2==TACT_OFF → S_UP_WAIT with db_cnt=1.
  - S_UP_WAIT: if s2==TACT_ON → S_DOWN, db_cnt=0 (glitch rejected; long_cnt resumes from its held value). Else if db_cnt==DB_CYCLES-1 → S_UP, Tact_db<=TACT_OFF, pressed<=0, release_pulse<=1. Else db_cnt+1. long_cnt holds in this state.
- DB_CYCLES=1: the WAIT states accept on their first cycle, i.e. a one-cycle-registered pass-through.
- Long press: in S_DOWN with long_fired==0 and long_cnt==LONG_CYCLES-1 → long_press<=1, long_fired<=1, long_cnt holds. There is no repeat until a release is accepted.
- All outputs are registered. Pulses are high for exactly one cycle, the cycle Tact_db changes.
- Latency: a clean edge on Tact_raw settles. Tact_db/pressed/pulse update DB_CYCLES+2 rising edges later (2 sync + DB_CYCLES accept).
- Counters never wrap. db_cnt ≤ DB_CYCLES-1. long_cnt saturates at LONG_CYCLES-1.
- press_pulse and release_pulse are mutually exclusive. long_press never coincides with press_pulse (needs LONG_CYCLES ≥ 1 cycle in S_DOWN).

Decomposition:
- Shared package tact_pkg holds:
  - TACT_ON/TACT_OFF constants, so the blinker and this block agree on polarity;
  - the 2-bit state encoding S_UP=0, S_DN_WAIT=1, S_DOWN=2, S_UP_WAIT=3.
- One natural sub-module: tact_sync. It is the 2-flop synchroniser, reset value TACT_OFF, parameterised on reset value, and reusable for other board inputs.
- FSM and counters stay in tact_debounce.

Test Plan (DB_CYCLES=4, LONG_CYCLES=16, W_DB=3, W_LONG=5):
- Reset, then hold Tact_raw=1 for 20 cycles → Tact_db=1, pressed=0, all pulses 0 throughout.
- Drive Tact_raw 1→0 cleanly at cycle 0 → press_pulse=1 for exactly one cycle at edge 6; Tact_db=0 and pressed=1 from edge 6.
- Bounce: Tact_raw low 3 cycles, high 1, low 3, high → no press_pulse, Tact_db stays 1, FSM back in S_UP.
- Hold pressed for 30 cycles after acceptance → long_press single pulse 16 cycles after press_pulse, no repeat. Release → release_pulse after 6 cycles.
- Release glitch during hold: high for 2 cycles at hold cycle 5, then low again → no release_pulse. long_press fires at cycle 18 (2-cycle hold pause).
- Assert RST for 1 cycle mid S_DN_WAIT and again mid S_DOWN with the switch held → outputs return to released/0 on the next edge. With the switch still held, press is re-accepted 6 cycles after RST deasserts.
